// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: imem fetch handshake, EX redirect inputs, flush/exception outputs.
interface pc_sequencer_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        jalr_valid;
  logic [31:0] jalr_base;
  logic [31:0] jalr_imm;
  logic        flush;
  logic        misalign_exc;
  logic [31:0] exc_addr;

  modport master (
    output fetch_valid, fetch_pc, flush, misalign_exc, exc_addr,
    input  fetch_ready, br_valid, br_taken, br_pc, br_imm,
           jalr_valid, jalr_base, jalr_imm
  );

  modport slave (
    input  fetch_valid, fetch_pc, flush, misalign_exc, exc_addr,
    output fetch_ready, br_valid, br_taken, br_pc, br_imm,
           jalr_valid, jalr_base, jalr_imm
  );
endinterface

// File: rtl/pc_sequencer.sv
// RV32I fetch PC sequencer: sequential fetch, branch/JAL/JALR redirects, wrong-path flush.
// Optional macro PC_MISALIGN_TRAP_EN: traps bit[1]-misaligned targets instead of masking them.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  pc_sequencer_if.master   bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]      state_q,    state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q,  pend_pc_d;
  logic            flush_q,    flush_d;
  logic            exc_q,      exc_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;

  logic            br_take;
  logic            take;
  logic            trap;
  logic            redirect;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] tgt;

  // Target selection: a taken branch has priority over a simultaneous JALR.
  always_comb begin
    br_take  = bus.br_valid & bus.br_taken;
    take     = br_take | bus.jalr_valid;
    br_tgt   = bus.br_pc + {bus.br_imm[XLEN-2:0], 1'b0};
    jalr_tgt = (bus.jalr_base + bus.jalr_imm) & ~XLEN'(1);
    raw_tgt  = br_take ? br_tgt : jalr_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    tgt      = raw_tgt;
    trap     = take & raw_tgt[1];
`else
    tgt      = raw_tgt & ~XLEN'(3);
    trap     = 1'b0;
`endif
    redirect = take & ~trap;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    flush_d    = 1'b0;
    exc_d      = 1'b0;
    exc_addr_d = '0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        flush_d    = take;
        exc_d      = trap;
        exc_addr_d = trap ? tgt : '0;
        if (redirect && bus.fetch_ready) begin
          fetch_pc_d = tgt;
        end else if (redirect) begin
          // Keep the outstanding request stable; issue the target after it is accepted.
          pend_pc_d = tgt;
          state_d   = PEND;
        end else if (bus.fetch_ready) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      PEND: begin
        flush_d    = take | bus.fetch_ready;
        exc_d      = trap;
        exc_addr_d = trap ? tgt : '0;
        if (redirect && bus.fetch_ready) begin
          fetch_pc_d = tgt;
          state_d    = RUN;
        end else if (redirect) begin
          pend_pc_d = tgt;
        end else if (bus.fetch_ready) begin
          fetch_pc_d = pend_pc_q;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      flush_q    <= 1'b0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      flush_q    <= flush_d;
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign bus.fetch_valid  = (state_q != BOOT);
  assign bus.fetch_pc     = fetch_pc_q;
  assign bus.flush        = flush_q;
  assign bus.misalign_exc = exc_q;
  assign bus.exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pc_sequencer_if ifc ();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Reference model: "pending target" is an optional address waiting for the current fetch to go.
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend_pc;
  bit          m_flush;
  bit          m_exc;
  logic [31:0] m_exc_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step();
    bit          br_t, take, trap;
    logic [31:0] t;
    if (rst) begin
      m_boot = 1; m_pc = RST_PC; m_pend_v = 0; m_pend_pc = '0;
      m_flush = 0; m_exc = 0; m_exc_addr = '0;
      return;
    end
    if (m_boot) begin
      m_boot = 0; m_flush = 0; m_exc = 0; m_exc_addr = '0;
      return;
    end
    br_t = ifc.br_valid && ifc.br_taken;
    take = br_t || ifc.jalr_valid;
    if (br_t) t = ifc.br_pc + ifc.br_imm * 2;
    else      t = (ifc.jalr_base + ifc.jalr_imm) & 32'hFFFF_FFFE;
`ifdef PC_MISALIGN_TRAP_EN
    trap = take && t[1];
`else
    trap = 0;
    t    = t & 32'hFFFF_FFFC;
`endif
    m_flush    = take;
    m_exc      = trap;
    m_exc_addr = trap ? t : 32'h0;
    if (take && !trap) begin
      if (ifc.fetch_ready) begin
        m_pc = t; m_pend_v = 0;
      end else begin
        m_pend_v = 1; m_pend_pc = t;
      end
    end else if (ifc.fetch_ready) begin
      if (m_pend_v) begin
        m_pc = m_pend_pc; m_pend_v = 0; m_flush = 1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    check("fetch_valid", 32'(ifc.fetch_valid), 32'(!m_boot));
    check("fetch_pc", ifc.fetch_pc, m_pc);
    check("flush", 32'(ifc.flush), 32'(m_flush));
    check("misalign_exc", 32'(ifc.misalign_exc), 32'(m_exc));
    check("exc_addr", ifc.exc_addr, m_exc_addr);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_redirects();
    ifc.br_valid = 0; ifc.br_taken = 0; ifc.br_pc = '0; ifc.br_imm = '0;
    ifc.jalr_valid = 0; ifc.jalr_base = '0; ifc.jalr_imm = '0;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] imm);
    ifc.br_valid = 1; ifc.br_taken = 1; ifc.br_pc = pc; ifc.br_imm = imm;
  endtask

  task automatic set_jalr(input logic [31:0] base, input logic [31:0] imm);
    ifc.jalr_valid = 1; ifc.jalr_base = base; ifc.jalr_imm = imm;
  endtask

  initial begin
    rst = 1;
    ifc.fetch_ready = 1;
    clear_redirects();
    cycle();
    cycle();
    check("rst_valid", 32'(ifc.fetch_valid), 32'h0);
    check("rst_pc", ifc.fetch_pc, RST_PC);

    // Reset release and sequential fetch.
    rst = 0;
    cycle(); check("seq0", ifc.fetch_pc, 32'h100);
    cycle(); check("seq1", ifc.fetch_pc, 32'h104);
    cycle(); check("seq2", ifc.fetch_pc, 32'h108);

    // Get to 0x200, then backward branch to 0x1E8.
    set_br(32'h100, 32'h80);
    cycle(); check("to200", ifc.fetch_pc, 32'h200);
    set_br(32'h1F8, 32'hFFFF_FFF8);
    cycle(); check("br_1e8", ifc.fetch_pc, 32'h1E8);
    check("br_flush", 32'(ifc.flush), 32'h1);
    clear_redirects();
    cycle(); check("br_flush_off", 32'(ifc.flush), 32'h0);

    // JALR alone, then JALR racing a taken branch.
    set_jalr(32'h1001, 32'h4);
    cycle(); check("jalr", ifc.fetch_pc, 32'h1004);
    set_br(32'h200, 32'h80);
    cycle(); check("br_wins", ifc.fetch_pc, 32'h300);
    clear_redirects();

    // Redirect under back-pressure.
    set_jalr(32'h40, 32'h0);
    cycle(); check("to40", ifc.fetch_pc, 32'h40);
    clear_redirects();
    ifc.fetch_ready = 0;
    set_br(32'h40, 32'h20);
    cycle(); check("stall_hold", ifc.fetch_pc, 32'h40);
    clear_redirects();
    cycle(); check("stall_hold2", ifc.fetch_pc, 32'h40);
    cycle();
    ifc.fetch_ready = 1;
    cycle(); check("stall_release", ifc.fetch_pc, 32'h80);
    check("stall_flush2", 32'(ifc.flush), 32'h1);
    cycle(); check("after_release", ifc.fetch_pc, 32'h84);

    // Misaligned branch target.
    set_br(32'h1000, 32'h1);
    cycle();
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_exc", 32'(ifc.misalign_exc), 32'h1);
    check("mis_addr", ifc.exc_addr, 32'h1002);
    check("mis_pc", ifc.fetch_pc, 32'h88);
`else
    check("mis_pc", ifc.fetch_pc, 32'h1000);
    check("mis_exc", 32'(ifc.misalign_exc), 32'h0);
`endif
    clear_redirects();

    // Reset while a target is pending.
    ifc.fetch_ready = 0;
    set_br(32'h500, 32'h0);
    cycle();
    clear_redirects();
    rst = 1;
    cycle(); check("pend_rst_valid", 32'(ifc.fetch_valid), 32'h0);
    check("pend_rst_pc", ifc.fetch_pc, RST_PC);
    rst = 0;
    ifc.fetch_ready = 1;
    cycle(); check("pend_rst_first", ifc.fetch_pc, RST_PC);
    cycle(); check("pend_rst_next", ifc.fetch_pc, 32'h104);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      ifc.fetch_ready = ($urandom_range(0, 3) != 0);
      ifc.br_valid    = ($urandom_range(0, 5) == 0);
      ifc.br_taken    = $urandom_range(0, 1) == 1;
      ifc.br_pc       = $urandom & 32'hFFFF_FFFC;
      ifc.br_imm      = 32'($urandom_range(0, 1023)) - 32'd512;
      ifc.jalr_valid  = ($urandom_range(0, 7) == 0);
      ifc.jalr_base   = $urandom;
      ifc.jalr_imm    = 32'($urandom_range(0, 4095)) - 32'd2048;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program-counter sequencer for the RV32I core. It owns the PC register and issues fetch addresses to instruction memory over a valid/ready handshake. It applies branch/JAL redirects (target = branch PC + immediate shifted left by one) and JALR redirects from EX, and generates the flush pulse that kills wrong-path instructions. It sits between EX branch resolution and the instruction-memory port.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_valid  out  1  fetch_pc holds a request
- fetch_ready  in  1  imem/decode accepts the request (includes decode back-pressure)
- fetch_pc  out  32  fetch address, registered
- br_valid  in  1  EX resolved a branch/JAL this cycle
- br_taken  in  1  resolved taken (ignored unless br_valid)
- br_pc  in  32  PC of the branch/JAL instruction
- br_imm  in  32  sign-extended immediate in halfword units
- jalr_valid  in  1  EX resolved a JALR this cycle
- jalr_base  in  32  rs1 value
- jalr_imm  in  32  sign-extended I-immediate
- flush  out  1  one-cycle pulse: drop the instruction in IF/ID
- misalign_exc  out  1  one-cycle misaligned-target exception (tied 0 unless macro)
- exc_addr  out  32  offending target (valid with misalign_exc; 0 otherwise)

## Operation
- States: BOOT, RUN, PEND.
- BOOT: reset state; fetch_valid=0. Exits to RUN on the first edge that samples rst=0.
- RUN: fetch_valid=1. On accept (fetch_valid & fetch_ready), fetch_pc <= fetch_pc+4, mod 2^32.
- Redirect request in a cycle: take = (br_valid & br_taken) | jalr_valid. If br_valid & br_taken and jalr_valid are both high, the branch wins.
- Branch target = br_pc + {br_imm[30:0],1'b0}, 32-bit wrap.
- JALR target = (jalr_base + jalr_imm) & ~32'h1, 32-bit wrap.
- RUN with take and fetch_ready=1, or RUN with take and no outstanding request: fetch_pc <= target; flush=1 next cycle; stays RUN.
- RUN with take while fetch_valid & !fetch_ready: fetch_pc held, so the request stays stable. Target is latched into pend_pc and the state goes to PEND. flush=1 next cycle.
- PEND: fetch_valid=1 with the old fetch_pc. On accept, fetch_pc <= pend_pc, flush=1 next cycle (kills the stale fetch), state -> RUN.
- PEND with a new take: pend_pc is overwritten by the new target, and flush pulses next cycle.
- br_valid with br_taken=0: no effect.
- rst mid-operation (any state, including PEND): next cycle is BOOT, fetch_pc=RESET_PC, pend_pc cleared, flush=0, misalign_exc=0.

## Timing
- Reset values: fetch_valid=0, fetch_pc=RESET_PC, flush=0, misalign_exc=0, exc_addr=0, pend_pc=0.
- First request: fetch_valid=1 with fetch_pc=RESET_PC in the first cycle after rst is sampled low.
- Redirect latency: take in cycle N gives fetch_pc=target and flush=1 in cycle N+1 (RUN, no stall).
- Back-to-back accepts sustain one fetch per cycle.
- All outputs are registered except fetch_valid, which is decoded from state.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A selected target with bit[1]=1 does not redirect and does not change state.
  - misalign_exc=1 and exc_addr=target in cycle N+1; flush=1 in N+1.
  - A non-taken selection never traps.
- Not defined:
  - target[1:0] is forced to 2'b00 before use.
  - misalign_exc and exc_addr are constant 0.

## Test plan
- Reset release with fetch_ready=1, RESET_PC=32'h100 -> fetch_pc 0x100, 0x104, 0x108 on consecutive cycles; flush=0.
- At fetch_pc=0x200: br_pc=0x1F8, br_imm=32'hFFFF_FFF8, taken -> next fetch_pc=0x1E8, flush=1 for exactly one cycle.
- JALR with jalr_base=0x1001, jalr_imm=4 -> fetch_pc=0x1004. Same cycle as a taken branch to 0x300 -> fetch_pc=0x300.
- fetch_ready=0 at fetch_pc=0x40 with a branch taken to 0x80 -> fetch_pc stays 0x40 until ready. Then 0x80 next cycle, with two flush pulses total.
- With PC_MISALIGN_TRAP_EN, branch target 0x1002 -> misalign_exc=1, exc_addr=0x1002, fetch_pc continues sequentially. Without the macro, fetch_pc=0x1000.
- rst asserted while in PEND -> next cycle fetch_valid=0, fetch_pc=RESET_PC; the pending target is never issued.
